cm_sort_arb: RTL and testbench
==============================

# cm_sort_arb

Round-robin arbiter and sequencer that shares one sorting-network instance (`cm_sort`) between `REQ_CNT` independent requesters. It accepts full vectors over valid/ready handshakes and issues one vector per cycle to the sorter. The originating requester ID is tracked through the sorter's variable latency. Sorted results are returned through a tagged, back-pressurable response queue. Credit-based admission guarantees no result is ever dropped.

## Interface
- `REQ_CNT`, 4: number of requesters, 2..16.
- `DCNT`, 4: elements per vector; matches the sorter's `DCNT`.
- `DWIDTH`, 8: element width; matches the sorter's `DWIDTH`.
- `FIFO_DEPTH`, 4: tag queue depth, response queue depth and credit pool size; power of two, ≥2.

Ports:
- `i_clk`  in  1  single clock; all logic rising-edge.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_req_vld`  in  `REQ_CNT`  per-requester vector valid.
- `i_req_data`  in  `[REQ_CNT][DCNT][DWIDTH]`  per-requester unsorted vector.
- `o_req_rdy`  out  `REQ_CNT`  per-requester accept; at most one bit high.
- `o_srt_vld`  out  1  vector valid to the sorter.
- `o_srt_data`  out  `[DCNT][DWIDTH]`  vector to the sorter.
- `i_srt_vld`  in  1  sorted result valid from the sorter.
- `i_srt_data`  in  `[DCNT][DWIDTH]`  sorted result.
- `o_rsp_vld`  out  1  response queue not empty.
- `o_rsp_id`  out  `$clog2(REQ_CNT)`  requester that owns the head response.
- `o_rsp_data`  out  `[DCNT][DWIDTH]`  head sorted vector.
- `i_rsp_rdy`  in  1  consumer accepts the head response.
- `o_err`  out  1  sticky protocol error.

## Operation
- **Credits.** `credit` counts from 0 to `FIFO_DEPTH` and resets to `FIFO_DEPTH`.
  - An issue decrements it.
  - A response pop (`o_rsp_vld && i_rsp_rdy`) increments it.
  - Both events in the same cycle leave it unchanged.
- **Arbitration.**
  - When `credit > 0`, grant the first requester with `i_req_vld` high, searching from `rr_ptr` upward with wrap-around.
  - `o_req_rdy` is one-hot on the granted requester, and all zero when `credit == 0` or no request is valid.
  - After a grant to requester k, `rr_ptr` becomes `(k+1) mod REQ_CNT`. Without a grant, `rr_ptr` holds. `rr_ptr` resets to 0.
- **Issue.** On a handshake:
  - The vector is registered onto `o_srt_data`.
  - `o_srt_vld` pulses for one cycle.
  - The ID k is pushed into the tag queue in the same cycle.
- **Return.** On `i_srt_vld`:
  - Pop the head tag.
  - Push `{tag, i_srt_data}` into the response queue.
  - Returns are in issue order; the sorter latency is arbitrary but fixed.
- **Errors.**
  - `i_srt_vld` with an empty tag queue sets `o_err`. Nothing is pushed and credit is unchanged.
  - `o_err` clears only on reset.
- **Queue safety.** Credits bound (outstanding tags + response entries) to at most `FIFO_DEPTH`, so neither queue can overflow.
- **Reset mid-operation.**
  - All queues empty, credit refilled, `rr_ptr` cleared.
  - Results in flight inside the sorter that arrive after reset set `o_err`.

## Timing
- **Reset values.** `o_req_rdy` = 0, `o_srt_vld` = 0, `o_srt_data` = 0, `o_rsp_vld` = 0, `o_rsp_id` = 0, `o_rsp_data` = 0, `o_err` = 0.
- **Combinational outputs.** `o_req_rdy` is combinational from `i_req_vld`, `rr_ptr` and `credit`. The credit it sees is the registered value; credit returned by a pop in the current cycle is usable the next cycle.
- **Issue latency.** `o_srt_vld` rises 1 cycle after the request handshake.
- **Response latency.** `o_rsp_vld` rises 1 cycle after `i_srt_vld`. Total latency is 2 + the sorter latency.
- **Queue behaviour.** The response queue is first-word-fall-through. Head outputs are stable while `o_rsp_vld && !i_rsp_rdy`.
- **Throughput.** One issue per cycle when `FIFO_DEPTH ≥ sorter latency + 3` and `i_rsp_rdy` is held high.

## Configuration
- **`CM_SORT_ARB_STAT_EN` defined.**
  - Adds output `o_stat_cnt` [`REQ_CNT`][16]: per-requester saturating count of accepted vectors.
  - Reset value 0; the count holds at 16'hFFFF once saturated.
  - Increments in the handshake cycle, visible the next cycle.
- **Not defined.** The port and counters are absent; all other behaviour is identical.

## Test plan
- **Single request, sorter latency 1.**
  - Stimulus: requester 2 sends {4,1,3,2}.
  - Required: `o_srt_vld` at T+1; sorter returns {1,2,3,4}; `o_rsp_vld` at T+3 with `o_rsp_id` = 2.
- **Fairness.**
  - Stimulus: all 4 requesters valid continuously, `i_rsp_rdy` = 1.
  - Required: grant order 0,1,2,3,0,1…; each requester gets exactly 25 grants in 100 grants.
- **Back-pressure.**
  - Stimulus: `i_rsp_rdy` = 0 with `FIFO_DEPTH` = 4.
  - Required: exactly 4 handshakes, then `o_req_rdy` = 0. One pop re-enables exactly one grant on the following cycle.
- **Simultaneous issue and pop with credit = 1.**
  - Required: credit stays 1, with no loss or duplication over 50 cycles.
- **Error.**
  - Stimulus: `i_srt_vld` pulse with nothing outstanding.
  - Required: `o_err` = 1 the next cycle and stays set until `i_rst`; the response queue stays empty.
- **Reset mid-stream.**
  - Stimulus: `i_rst` asserted while 3 responses are pending.
  - Required: all outputs at their reset values immediately; credit = 4 and `rr_ptr` = 0 after release.

Source files
------------

// File: rtl/cm_sort_arb.sv
// Round-robin arbiter sharing one sorter between REQ_CNT requesters; tags track result ownership.
// Optional feature: define CM_SORT_ARB_STAT_EN to add per-requester accepted-vector counters.
module cm_sort_arb #(
  parameter int REQ_CNT    = 4,
  parameter int DCNT       = 4,
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic [REQ_CNT-1:0]                          i_req_vld,
  input  logic [REQ_CNT-1:0][DCNT-1:0][DWIDTH-1:0]    i_req_data,
  output logic [REQ_CNT-1:0]                          o_req_rdy,
  output logic                                        o_srt_vld,
  output logic [DCNT-1:0][DWIDTH-1:0]                 o_srt_data,
  input  logic                                        i_srt_vld,
  input  logic [DCNT-1:0][DWIDTH-1:0]                 i_srt_data,
  output logic                                        o_rsp_vld,
  output logic [$clog2(REQ_CNT)-1:0]                  o_rsp_id,
  output logic [DCNT-1:0][DWIDTH-1:0]                 o_rsp_data,
  input  logic                                        i_rsp_rdy,
  output logic                                        o_err
`ifdef CM_SORT_ARB_STAT_EN
  ,
  output logic [REQ_CNT-1:0][15:0]                    o_stat_cnt
`endif
);

  localparam int IDW = $clog2(REQ_CNT);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]                   credit_q, credit_d;
  logic [IDW-1:0]                  rr_q, rr_d;
  logic                            srt_vld_q, srt_vld_d;
  logic [DCNT-1:0][DWIDTH-1:0]     srt_data_q, srt_data_d;
  logic [IDW-1:0]                  tag_mem_q [FIFO_DEPTH];
  logic [IDW-1:0]                  tag_mem_d [FIFO_DEPTH];
  logic [PW-1:0]                   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0]                   tag_cnt_q, tag_cnt_d;
  logic [IDW-1:0]                  rsp_id_mem_q [FIFO_DEPTH];
  logic [IDW-1:0]                  rsp_id_mem_d [FIFO_DEPTH];
  logic [DCNT-1:0][DWIDTH-1:0]     rsp_data_mem_q [FIFO_DEPTH];
  logic [DCNT-1:0][DWIDTH-1:0]     rsp_data_mem_d [FIFO_DEPTH];
  logic [PW-1:0]                   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0]                   rsp_cnt_q, rsp_cnt_d;
  logic                            err_q, err_d;

  logic [REQ_CNT-1:0]              gnt_s;
  logic [IDW-1:0]                  gnt_id_s;
  logic                            gnt_vld_s;
  logic [IDW:0]                    idx_s;
  logic                            issue_s, pop_s, ret_s;

  // Search from rr_q upward with wrap; grant only with credit available and outside reset.
  always_comb begin
    gnt_s     = '0;
    gnt_id_s  = '0;
    gnt_vld_s = 1'b0;
    idx_s     = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      idx_s = {1'b0, rr_q} + (IDW+1)'(i);
      if (idx_s >= (IDW+1)'(REQ_CNT)) begin
        idx_s = idx_s - (IDW+1)'(REQ_CNT);
      end else begin
        idx_s = idx_s;
      end
      if (!gnt_vld_s && i_req_vld[idx_s[IDW-1:0]]) begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = idx_s[IDW-1:0];
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    if (gnt_vld_s && (credit_q != '0) && !i_rst) begin
      gnt_s[gnt_id_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  assign issue_s = |gnt_s;
  assign pop_s   = (rsp_cnt_q != '0) && i_rsp_rdy;
  assign ret_s   = i_srt_vld && (tag_cnt_q != '0);

  // Next state for issue register, tag queue, response queue, credit and error flag.
  always_comb begin
    credit_d       = credit_q;
    rr_d           = rr_q;
    srt_vld_d      = issue_s;
    srt_data_d     = srt_data_q;
    tag_mem_d      = tag_mem_q;
    tag_wr_d       = tag_wr_q;
    tag_rd_d       = tag_rd_q;
    tag_cnt_d      = tag_cnt_q;
    rsp_id_mem_d   = rsp_id_mem_q;
    rsp_data_mem_d = rsp_data_mem_q;
    rsp_wr_d       = rsp_wr_q;
    rsp_rd_d       = rsp_rd_q;
    rsp_cnt_d      = rsp_cnt_q;
    err_d          = err_q | (i_srt_vld && (tag_cnt_q == '0));

    if (issue_s) begin
      srt_data_d          = i_req_data[gnt_id_s];
      tag_mem_d[tag_wr_q] = gnt_id_s;
      tag_wr_d            = tag_wr_q + PW'(1);
      rr_d                = (gnt_id_s == IDW'(REQ_CNT - 1)) ? '0 : gnt_id_s + IDW'(1);
    end else begin
      srt_data_d = srt_data_q;
    end

    // A return without an outstanding tag is dropped; only err_d records it.
    if (ret_s) begin
      rsp_id_mem_d[rsp_wr_q]   = tag_mem_q[tag_rd_q];
      rsp_data_mem_d[rsp_wr_q] = i_srt_data;
      rsp_wr_d                 = rsp_wr_q + PW'(1);
      tag_rd_d                 = tag_rd_q + PW'(1);
    end else begin
      rsp_wr_d = rsp_wr_q;
    end

    if (pop_s) begin
      rsp_rd_d = rsp_rd_q + PW'(1);
    end else begin
      rsp_rd_d = rsp_rd_q;
    end

    case ({issue_s, ret_s})
      2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase

    case ({ret_s, pop_s})
      2'b10:   rsp_cnt_d = rsp_cnt_q + CW'(1);
      2'b01:   rsp_cnt_d = rsp_cnt_q - CW'(1);
      default: rsp_cnt_d = rsp_cnt_q;
    endcase

    case ({issue_s, pop_s})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      credit_q       <= CW'(FIFO_DEPTH);
      rr_q           <= '0;
      srt_vld_q      <= 1'b0;
      srt_data_q     <= '0;
      tag_mem_q      <= '{default: '0};
      tag_wr_q       <= '0;
      tag_rd_q       <= '0;
      tag_cnt_q      <= '0;
      rsp_id_mem_q   <= '{default: '0};
      rsp_data_mem_q <= '{default: '0};
      rsp_wr_q       <= '0;
      rsp_rd_q       <= '0;
      rsp_cnt_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      credit_q       <= credit_d;
      rr_q           <= rr_d;
      srt_vld_q      <= srt_vld_d;
      srt_data_q     <= srt_data_d;
      tag_mem_q      <= tag_mem_d;
      tag_wr_q       <= tag_wr_d;
      tag_rd_q       <= tag_rd_d;
      tag_cnt_q      <= tag_cnt_d;
      rsp_id_mem_q   <= rsp_id_mem_d;
      rsp_data_mem_q <= rsp_data_mem_d;
      rsp_wr_q       <= rsp_wr_d;
      rsp_rd_q       <= rsp_rd_d;
      rsp_cnt_q      <= rsp_cnt_d;
      err_q          <= err_d;
    end
  end

  assign o_req_rdy  = gnt_s;
  assign o_srt_vld  = srt_vld_q;
  assign o_srt_data = srt_data_q;
  assign o_rsp_vld  = (rsp_cnt_q != '0);
  assign o_rsp_id   = o_rsp_vld ? rsp_id_mem_q[rsp_rd_q] : '0;
  assign o_rsp_data = o_rsp_vld ? rsp_data_mem_q[rsp_rd_q] : '0;
  assign o_err      = err_q;

`ifdef CM_SORT_ARB_STAT_EN
  logic [REQ_CNT-1:0][15:0] stat_q, stat_d;

  // Saturating per-requester accept counters.
  always_comb begin
    stat_d = stat_q;
    if (issue_s && (stat_q[gnt_id_s] != 16'hFFFF)) begin
      stat_d[gnt_id_s] = stat_q[gnt_id_s] + 16'd1;
    end else begin
      stat_d = stat_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign o_stat_cnt = stat_q;
`else
`endif

endmodule

// File: tb/tb_cm_sort_arb.sv
// Directed self-checking bench for cm_sort_arb; the bench plays the sorter (latency 1) when echo_en is set.
module tb_cm_sort_arb;

  logic                       clk;
  logic                       i_rst;
  logic [3:0]                 i_req_vld;
  logic [3:0][3:0][7:0]       i_req_data;
  logic [3:0]                 o_req_rdy;
  logic                       o_srt_vld;
  logic [3:0][7:0]            o_srt_data;
  logic                       i_srt_vld;
  logic [3:0][7:0]            i_srt_data;
  logic                       o_rsp_vld;
  logic [1:0]                 o_rsp_id;
  logic [3:0][7:0]            o_rsp_data;
  logic                       i_rsp_rdy;
  logic                       o_err;
`ifdef CM_SORT_ARB_STAT_EN
  logic [3:0][15:0]           o_stat_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic            echo_en = 1'b0;
  logic            prev_v = 1'b0;
  logic [3:0][7:0] prev_d = '0;

  cm_sort_arb dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_vld(i_req_vld), .i_req_data(i_req_data), .o_req_rdy(o_req_rdy),
    .o_srt_vld(o_srt_vld), .o_srt_data(o_srt_data),
    .i_srt_vld(i_srt_vld), .i_srt_data(i_srt_data),
    .o_rsp_vld(o_rsp_vld), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
    .i_rsp_rdy(i_rsp_rdy), .o_err(o_err)
`ifdef CM_SORT_ARB_STAT_EN
    , .o_stat_cnt(o_stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge; when echoing, return last cycle's issue one cycle later.
  task automatic step();
    @(negedge clk);
    if (echo_en) begin
      i_srt_vld  = prev_v;
      i_srt_data = prev_d;
      prev_v     = o_srt_vld;
      prev_d     = o_srt_data;
    end
  endtask

  task automatic apply_reset();
    i_rst = 1'b1; i_req_vld = '0; i_req_data = '0; i_srt_vld = 1'b0; i_srt_data = '0;
    i_rsp_rdy = 1'b0; echo_en = 1'b0; prev_v = 1'b0; prev_d = '0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy: got %b exp 0000", o_req_rdy); end
    checks++; if (o_srt_vld !== 1'b0) begin errors++; $display("FAIL reset_srt_vld: got %b exp 0", o_srt_vld); end
    checks++; if (o_srt_data !== 32'h0) begin errors++; $display("FAIL reset_srt_data: got %h exp 0", o_srt_data); end
    checks++; if (o_rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: got %b exp 0", o_rsp_vld); end
    checks++; if (o_rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d exp 0", o_rsp_id); end
    checks++; if (o_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h exp 0", o_rsp_data); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", o_err); end
  endtask

  task automatic test_single();
    apply_reset();
    i_req_vld = 4'b0100;
    i_req_data[2] = {8'd4, 8'd1, 8'd3, 8'd2};
    #1;
    checks++; if (o_req_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy: got %b exp 0100", o_req_rdy); end
    step();
    i_req_vld = 4'b0000;
    #1;
    checks++; if (o_srt_vld !== 1'b1) begin errors++; $display("FAIL single_srt_vld: got %b exp 1", o_srt_vld); end
    checks++; if (o_srt_data !== 32'h04010302) begin errors++; $display("FAIL single_srt_data: got %h exp 04010302", o_srt_data); end
    step();
    checks++; if (o_srt_vld !== 1'b0) begin errors++; $display("FAIL single_srt_pulse: got %b exp 0", o_srt_vld); end
    checks++; if (o_rsp_vld !== 1'b0) begin errors++; $display("FAIL single_rsp_early: got %b exp 0", o_rsp_vld); end
    i_srt_vld = 1'b1;
    i_srt_data = {8'd1, 8'd2, 8'd3, 8'd4};
    step();
    i_srt_vld = 1'b0;
    #1;
    checks++; if (o_rsp_vld !== 1'b1) begin errors++; $display("FAIL single_rsp_vld: got %b exp 1", o_rsp_vld); end
    checks++; if (o_rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d exp 2", o_rsp_id); end
    checks++; if (o_rsp_data !== 32'h01020304) begin errors++; $display("FAIL single_rsp_data: got %h exp 01020304", o_rsp_data); end
    step();
    checks++; if (o_rsp_vld !== 1'b1 || o_rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_hold: got vld %b id %0d exp 1 2", o_rsp_vld, o_rsp_id); end
    i_rsp_rdy = 1'b1;
    step();
    i_rsp_rdy = 1'b0;
    #1;
    checks++; if (o_rsp_vld !== 1'b0) begin errors++; $display("FAIL single_rsp_pop: got %b exp 0", o_rsp_vld); end
  endtask

  task automatic test_fairness();
    int exp_g = 0;
    int rexp = 0;
    int rcnt = 0;
    int cnt[4] = '{0, 0, 0, 0};
    logic [3:0] e;
    apply_reset();
    echo_en = 1'b1;
    i_rsp_rdy = 1'b1;
    i_req_vld = 4'hF;
    for (int k = 0; k < 4; k++) i_req_data[k] = {4{8'(k + 1)}};
    for (int c = 0; c < 100; c++) begin
      #1;
      e = 4'b0001 << exp_g;
      checks++; if (o_req_rdy !== e) begin errors++; $display("FAIL fair_grant cycle %0d: got %b exp %b", c, o_req_rdy, e); end
      for (int k = 0; k < 4; k++) if (o_req_rdy[k]) cnt[k]++;
      exp_g = (exp_g + 1) % 4;
      if (o_rsp_vld) begin
        checks++; if (o_rsp_id !== 2'(rexp) || o_rsp_data !== {4{8'(rexp + 1)}}) begin errors++; $display("FAIL fair_rsp: got id %0d data %h exp id %0d", o_rsp_id, o_rsp_data, rexp); end
        rexp = (rexp + 1) % 4;
        rcnt++;
      end
      step();
    end
    i_req_vld = 4'h0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (o_rsp_vld) begin
        checks++; if (o_rsp_id !== 2'(rexp) || o_rsp_data !== {4{8'(rexp + 1)}}) begin errors++; $display("FAIL fair_drain: got id %0d data %h exp id %0d", o_rsp_id, o_rsp_data, rexp); end
        rexp = (rexp + 1) % 4;
        rcnt++;
      end
      step();
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (cnt[k] != 25) begin errors++; $display("FAIL fair_count req %0d: got %0d exp 25", k, cnt[k]); end
    end
    checks++; if (rcnt != 100) begin errors++; $display("FAIL fair_responses: got %0d exp 100", rcnt); end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    apply_reset();
    echo_en = 1'b1;
    i_req_vld = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (o_req_rdy != 4'b0000) hs++;
      step();
    end
    #1;
    checks++; if (hs != 4) begin errors++; $display("FAIL bp_handshakes: got %0d exp 4", hs); end
    checks++; if (o_req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_stall: got %b exp 0000", o_req_rdy); end
    checks++; if (o_rsp_vld !== 1'b1) begin errors++; $display("FAIL bp_rsp_vld: got %b exp 1", o_rsp_vld); end
    i_rsp_rdy = 1'b1;
    #1;
    checks++; if (o_req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_same_cycle: got %b exp 0000", o_req_rdy); end
    step();
    i_rsp_rdy = 1'b0;
    #1;
    checks++; if (o_req_rdy !== 4'b0001) begin errors++; $display("FAIL bp_regrant: got %b exp 0001", o_req_rdy); end
    step();
    #1;
    checks++; if (o_req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_one_only: got %b exp 0000", o_req_rdy); end
  endtask

  task automatic test_credit_one();
    int seq = 3;
    int rseq = 0;
    apply_reset();
    echo_en = 1'b1;
    i_req_vld = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      i_req_data[0] = {4{8'(k)}};
      #1;
      checks++; if (o_req_rdy !== 4'b0001) begin errors++; $display("FAIL c1_fill %0d: got %b exp 0001", k, o_req_rdy); end
      step();
    end
    i_req_vld = 4'b0000;
    repeat (5) step();
    for (int c = 0; c < 50; c++) begin
      i_rsp_rdy = 1'b1;
      i_req_vld = 4'b0001;
      i_req_data[0] = {4{8'(seq)}};
      #1;
      checks++; if (dut.credit_q !== 3'd1) begin errors++; $display("FAIL c1_credit cycle %0d: got %0d exp 1", c, dut.credit_q); end
      checks++; if (o_req_rdy !== 4'b0001) begin errors++; $display("FAIL c1_grant cycle %0d: got %b exp 0001", c, o_req_rdy); end
      checks++; if (o_rsp_vld !== 1'b1 || o_rsp_data !== {4{8'(rseq)}}) begin errors++; $display("FAIL c1_rsp cycle %0d: got vld %b data %h exp seq %0d", c, o_rsp_vld, o_rsp_data, rseq); end
      seq++;
      rseq++;
      step();
    end
    i_req_vld = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (o_rsp_vld) begin
        checks++; if (o_rsp_data !== {4{8'(rseq)}}) begin errors++; $display("FAIL c1_drain: got %h exp seq %0d", o_rsp_data, rseq); end
        rseq++;
      end
      step();
    end
    #1;
    checks++; if (rseq != seq) begin errors++; $display("FAIL c1_total: got %0d exp %0d", rseq, seq); end
    checks++; if (o_rsp_vld !== 1'b0) begin errors++; $display("FAIL c1_empty: got %b exp 0", o_rsp_vld); end
  endtask

  task automatic test_error();
    apply_reset();
    i_srt_vld = 1'b1;
    i_srt_data = 32'hDEADBEEF;
    step();
    i_srt_vld = 1'b0;
    #1;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b exp 1", o_err); end
    checks++; if (o_rsp_vld !== 1'b0) begin errors++; $display("FAIL err_no_push: got %b exp 0", o_rsp_vld); end
    checks++; if (dut.credit_q !== 3'd4) begin errors++; $display("FAIL err_credit: got %0d exp 4", dut.credit_q); end
    repeat (5) step();
    #1;
    checks++; if (o_err !== 1'b1 || o_rsp_vld !== 1'b0) begin errors++; $display("FAIL err_sticky: got err %b vld %b exp 1 0", o_err, o_rsp_vld); end
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    apply_reset();
    echo_en = 1'b1;
    i_req_vld = 4'b0111;
    i_req_data[0] = 32'h11111111; i_req_data[1] = 32'h22222222; i_req_data[2] = 32'h33333333;
    repeat (3) step();
    i_req_vld = 4'b0000;
    repeat (4) step();
    #1;
    checks++; if (o_rsp_vld !== 1'b1 || o_rsp_id !== 2'd0) begin errors++; $display("FAIL mid_pending: got vld %b id %0d exp 1 0", o_rsp_vld, o_rsp_id); end
    checks++; if (o_srt_data !== 32'h33333333) begin errors++; $display("FAIL mid_srt_data: got %h exp 33333333", o_srt_data); end
    echo_en = 1'b0;
    i_srt_vld = 1'b0;
    i_req_vld = 4'hF;
    i_rst = 1'b1;
    #1;
    checks++; if (o_req_rdy !== 4'b0000 || o_srt_vld !== 1'b0 || o_srt_data !== 32'h0) begin errors++; $display("FAIL mid_rst_issue: got rdy %b vld %b data %h exp 0", o_req_rdy, o_srt_vld, o_srt_data); end
    checks++; if (o_rsp_vld !== 1'b0 || o_rsp_id !== 2'd0 || o_rsp_data !== 32'h0 || o_err !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp: got vld %b id %0d data %h err %b exp 0", o_rsp_vld, o_rsp_id, o_rsp_data, o_err); end
    step();
    i_rst = 1'b0;
    #1;
    checks++; if (o_req_rdy !== 4'b0001) begin errors++; $display("FAIL mid_rr_ptr: got %b exp 0001", o_req_rdy); end
    for (int c = 0; c < 7; c++) begin
      #1;
      if (o_req_rdy != 4'b0000) hs++;
      step();
    end
    checks++; if (hs != 4) begin errors++; $display("FAIL mid_credit: got %0d handshakes exp 4", hs); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_credit_one();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
